imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined RV immediate generator for the decode stage: takes a
//  32-bit instruction word plus format code and emits the XLEN-wide, correctly
//  sign-extended and shifted immediate to the ALU/branch operand muxes.
//  Valid/ready on both sides, 2-entry skid buffer so in_ready is registered.
//  Sign source is always instr[31], whatever the format.
// PARAMETERS
//  XLEN     64  datapath width; legal values 32 or 64
//  TAG_W    4   width of sideband tag carried alongside each instruction
// PORTS
//  clock      in   1      single clock, all state updates on posedge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      upstream offers instr/type/tag
//  in_ready   out  1      registered; high when a slot is free
//  in_instr   in   32     instruction word
//  in_type    in   3      imm_type_e format code
//  in_tag     in   TAG_W  sideband, passed through unchanged
//  out_valid  out  1      imm/tag/err valid
//  out_ready  in   1      downstream accepts
//  out_imm    out  XLEN   extended immediate
//  out_tag    out  TAG_W  tag of the same instruction
//  out_err    out  1      unsupported format code
// BEHAVIOUR
//  Clock: one clock, clock. Reset: synchronous, active-high, on reset.
//  Reset (all outputs): out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_err=0, state EMPTY.
//  Transfer: a beat moves when valid&&ready on the same edge.
//  Latency: accepted at edge N -> on outputs after edge N, i.e. out_valid=1 in cycle N+1.
//  Formats (s = instr[31] replicated):
//   000 I : {s, instr[30:20]}
//   001 S : {s, instr[30:25], instr[11:7]}
//   010 B : {s, instr[7], instr[30:25], instr[11:8], 1'b0}
//   011 J : {s, instr[19:12], instr[20], instr[30:21], 1'b0}
//   100 U : {s, instr[30:12], 12'b0}, upper bits sign-extended for XLEN=64
//   101 SHAMT : zero-ext instr[25:20] (XLEN=64) / instr[24:20] (XLEN=32)
//   110 ZIMM : see CONFIGURATION
//   111 : out_imm=0, out_err=1
//  FSM (main reg M, skid reg K):
//   EMPTY -> ONE on in accept.
//   ONE: accept & !drain -> FULL (new beat to K); drain & !accept -> EMPTY;
//    accept & drain -> ONE (new beat to M).
//   FULL: in_ready=0; on drain K->M, -> ONE.
//  in_ready = (state!=FULL), registered.
//  Order strictly preserved; no beat dropped or duplicated.
//  Outputs held stable while out_valid && !out_ready.
//  Reset mid-operation discards M and K contents; no partial beat is emitted.
// CONFIGURATION
//  IMM_ZIMM_EN defined: code 110 -> zero-ext instr[19:15] (CSR zimm), out_err=0.
//  IMM_ZIMM_EN undefined: code 110 treated as 111 (imm=0, err=1).
// STRUCTURE
//  Package imm_pkg: typedef enum logic [2:0] imm_type_e
//   (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_ZIMM, IMM_BAD);
//  typedef enum skid_state_e {EMPTY, ONE, FULL}; localparam XLEN_DEFAULT=64.
//  Sub-module imm_decode: purely combinational format->XLEN extender, instantiated once ahead of the skid regs.
//  Top holds FSM, M/K registers, handshake.
// TESTING
//  I: 0xFFF00093, type 000 -> out_imm 0xFFFF_FFFF_FFFF_FFFF, err 0, one cycle later.
//  S: 0xFE112E23 (sw x1,-4(x2)), type 001 -> 0xFFFF_FFFF_FFFF_FFFC.
//  U/J: 0x800002B7, type 100 -> 0xFFFF_FFFF_8000_0000; 0x0010006F, type 011 -> 0x0000_0000_0000_0800.
//  Backpressure: 4 back-to-back beats, tags 1..4, out_ready=0 for 3 cycles.
//   -> in_ready=0 after 2 accepted; released in order 1,2,3,4 with correct imm.
//  Type 110 and 111: 110 -> zimm (macro on) or err=1, imm=0 (off); 111 -> err=1, imm=0.
//  Reset asserted while FULL -> next cycle out_valid=0, in_ready=1, nothing stale emitted.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and defaults for the pipelined RV immediate generator.
//   imm_type_e   : 3-bit instruction format code driven by the decoder
//   skid_state_e : occupancy of the two-entry output skid buffer
//   XLEN_DEFAULT : default datapath width (legal widths are 32 and 64)
package imm_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_BAD   = 3'b111
  } imm_type_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational format decoder / extender: turns a 32-bit instruction word and a
// format code into the XLEN-wide immediate.
// Optional feature macro: IMM_ZIMM_EN (code 110 yields the CSR zimm field;
// without it code 110 is reported as an unsupported format).
// Ports:
//   instr_i : instruction word
//   type_i  : format code
//   imm_o   : extended immediate
//   err_o   : format code not supported
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr_i,
  input  imm_type_e       type_i,
  output logic [XLEN-1:0] imm_o,
  output logic            err_o
);

  logic        s;
  logic [31:0] imm32;
  logic        sext;

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr_i[6:0];

  assign s = instr_i[31];

  // Build a 32-bit result first, then widen; sext selects sign vs zero fill.
  always_comb begin
    imm32 = '0;
    sext  = 1'b1;
    err_o = 1'b0;
    unique case (type_i)
      IMM_I:     imm32 = {{20{s}}, instr_i[31:20]};
      IMM_S:     imm32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:     imm32 = {{20{s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J:     imm32 = {{12{s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      IMM_U:     imm32 = {instr_i[31:12], 12'b0};
      IMM_SHAMT: begin
        sext = 1'b0;
        if (XLEN == 64) begin
          imm32 = {26'b0, instr_i[25:20]};
        end else begin
          imm32 = {27'b0, instr_i[24:20]};
        end
      end
`ifdef IMM_ZIMM_EN
      IMM_ZIMM: begin
        sext  = 1'b0;
        imm32 = {27'b0, instr_i[19:15]};
      end
      IMM_BAD: begin
        sext  = 1'b0;
        err_o = 1'b1;
      end
`else
      IMM_ZIMM, IMM_BAD: begin
        sext  = 1'b0;
        err_o = 1'b1;
      end
`endif
      default: begin
        sext  = 1'b0;
        err_o = 1'b1;
      end
    endcase
  end

  always_comb begin
    imm_o        = (sext && imm32[31]) ? {XLEN{1'b1}} : {XLEN{1'b0}};
    imm_o[31:0]  = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator for the decode stage. The decoder sits ahead
// of a two-entry skid buffer (main reg M drives the outputs, skid reg K catches
// the beat accepted while the output is stalled), so in_ready is a flop.
// Optional feature macro: IMM_ZIMM_EN (enables CSR zimm for format code 110).
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   in_valid / in_ready : upstream handshake (in_ready registered)
//   in_instr, in_type   : instruction word and format code
//   in_tag              : sideband carried unchanged with the beat
//   out_valid/out_ready : downstream handshake
//   out_imm, out_tag    : extended immediate and its tag
//   out_err             : unsupported format code
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  skid_state_e state_q, state_d;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;

  logic [XLEN-1:0]  m_imm_q, k_imm_q;
  logic [TAG_W-1:0] m_tag_q, k_tag_q;
  logic             m_err_q, k_err_q;
  logic             in_ready_q;

  logic accept, drain;
  logic load_m_in, load_m_k, load_k;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i (in_instr),
    .type_i  (imm_type_e'(in_type)),
    .imm_o   (dec_imm),
    .err_o   (dec_err)
  );

  assign accept = in_valid && in_ready_q;
  assign drain  = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_k  = 1'b0;
    load_k    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_m_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_d = FULL;
          load_k  = 1'b1;
        end else if (drain && !accept) begin
          state_d = EMPTY;
        end else if (accept && drain) begin
          load_m_in = 1'b1;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          state_d  = ONE;
          load_m_k = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_imm_q    <= '0;
      m_tag_q    <= '0;
      m_err_q    <= 1'b0;
      k_imm_q    <= '0;
      k_tag_q    <= '0;
      k_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_m_in) begin
        m_imm_q <= dec_imm;
        m_tag_q <= in_tag;
        m_err_q <= dec_err;
      end else if (load_m_k) begin
        m_imm_q <= k_imm_q;
        m_tag_q <= k_tag_q;
        m_err_q <= k_err_q;
      end
      if (load_k) begin
        k_imm_q <= dec_imm;
        k_tag_q <= in_tag;
        k_err_q <= dec_err;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_imm   = m_imm_q;
  assign out_tag   = m_tag_q;
  assign out_err   = m_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed spec vectors, backpressure,
// reset while full, then randomized traffic against a queue-based model.
module tb_imm_gen_pipe;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [63:0]      imm;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_type;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  int checks   = 0;
  int failures = 0;

  exp_t model_q[$];

  imm_gen_pipe #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_type   (in_type),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Immediate value computed arithmetically from the field weights.
  function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] ty,
                                  output logic [63:0] imm, output logic err);
    longint n, v;
    n   = longint'(ins[31]);
    v   = 0;
    err = 1'b0;
    case (ty)
      3'd0: v = longint'(ins[31:20]) - n * 4096;
      3'd1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - n * 4096;
      3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                + longint'(ins[11:8]) * 2 - n * 4096;
      3'd3: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                + longint'(ins[30:21]) * 2 - n * (longint'(1) << 20);
      3'd4: v = longint'(ins[31:12]) * 4096 - n * (longint'(1) << 32);
      3'd5: v = longint'(ins[25:20]);
`ifdef IMM_ZIMM_EN
      3'd6: v = longint'(ins[19:15]);
`else
      3'd6: err = 1'b1;
`endif
      default: err = 1'b1;
    endcase
    imm = 64'(v);
  endfunction

  task automatic check_outputs();
    exp_t e;
    check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      e = model_q[0];
      check("out_imm", out_imm, e.imm);
      check("out_tag", 64'(out_tag), 64'(e.tag));
      check("out_err", 64'(out_err), 64'(e.err));
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, update the model for the
  // coming edge, then check outputs at the following negedge.
  task automatic step(input logic rst, input logic iv, input logic [31:0] ins,
                      input logic [2:0] ty, input logic [TAG_W-1:0] tg,
                      input logic ordy, output logic acc);
    exp_t e;
    logic [63:0] ei;
    logic ee;
    logic drn;
    reset     = rst;
    in_valid  = iv;
    in_instr  = ins;
    in_type   = ty;
    in_tag    = tg;
    out_ready = ordy;
    acc       = 1'b0;
    if (rst) begin
      model_q.delete();
    end else begin
      acc = iv && (model_q.size() < 2);
      drn = (model_q.size() > 0) && ordy;
      if (drn) void'(model_q.pop_front());
      if (acc) begin
        ref_imm(ins, ty, ei, ee);
        e.imm = ei;
        e.err = ee;
        e.tag = tg;
        model_q.push_back(e);
      end
    end
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  initial begin
    logic acc;
    int   idx;
    logic [31:0] dir_instr [4];
    logic [2:0]  dir_type  [4];
    logic [63:0] dir_imm   [4];

    dir_instr[0] = 32'hFFF00093; dir_type[0] = 3'd0; dir_imm[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    dir_instr[1] = 32'hFE112E23; dir_type[1] = 3'd1; dir_imm[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    dir_instr[2] = 32'h800002B7; dir_type[2] = 3'd4; dir_imm[2] = 64'hFFFF_FFFF_8000_0000;
    dir_instr[3] = 32'h0010006F; dir_type[3] = 3'd3; dir_imm[3] = 64'h0000_0000_0000_0800;

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_type = '0; in_tag = '0;
    out_ready = 1'b0;
    @(negedge clock);
    step(1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0, acc);
    step(1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0, acc);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);

    // Directed vectors: result must appear one cycle after acceptance.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, dir_instr[i], dir_type[i], 4'(i + 5), 1'b1, acc);
      check("dir_valid", 64'(out_valid), 64'd1);
      check("dir_imm", out_imm, dir_imm[i]);
      check("dir_err", 64'(out_err), 64'd0);
      step(1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b1, acc);
    end

    // Format codes 110 and 111.
    step(1'b0, 1'b1, 32'hFFFFFFFF, 3'd6, 4'd9, 1'b1, acc);
`ifdef IMM_ZIMM_EN
    check("zimm_imm", out_imm, 64'h1F);
    check("zimm_err", 64'(out_err), 64'd0);
`else
    check("zimm_imm", out_imm, 64'h0);
    check("zimm_err", 64'(out_err), 64'd1);
`endif
    step(1'b0, 1'b1, 32'hFFFFFFFF, 3'd7, 4'd10, 1'b1, acc);
    check("bad_imm", out_imm, 64'h0);
    check("bad_err", 64'(out_err), 64'd1);
    step(1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b1, acc);

    // Backpressure: four beats, tags 1..4, downstream stalled for 3 cycles.
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(1'b0, idx < 4, $urandom, 3'($urandom_range(0, 5)), 4'(idx + 1),
           cyc >= 3, acc);
      if (acc) idx++;
      if (cyc == 1) check("bp_full_ready", 64'(in_ready), 64'd0);
    end
    check("bp_all_accepted", 64'(idx), 64'd4);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset while FULL discards both entries.
    step(1'b0, 1'b1, 32'hFFF00093, 3'd0, 4'd1, 1'b0, acc);
    step(1'b0, 1'b1, 32'hFE112E23, 3'd1, 4'd2, 1'b0, acc);
    check("full_ready", 64'(in_ready), 64'd0);
    step(1'b1, 1'b1, 32'h800002B7, 3'd4, 4'd3, 1'b1, acc);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_imm", out_imm, 64'd0);
    step(1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b1, acc);
    check("post_rst_valid", 64'(out_valid), 64'd0);

    // Randomized traffic with occasional resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom,
           3'($urandom_range(0, 7)), 4'($urandom), $urandom_range(0, 9) < 6, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
